dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arbiter_rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_W = 14;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master not granted last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = 1'b0;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master (CPU/DMA) data-memory arbiter, IDLE -> ACCESS -> ACK per transaction.
// Optional misalignment trap: define DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              last_grant_q;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              m0_ack_q, m1_ack_q;
  logic              m0_err_q, m1_err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  logic              grant_d;
  logic              valid_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              misaligned_d;

  rr_arb2 u_rr_arb2 (
    .req_i        ({m1_req, m0_req}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_d),
    .valid_o      (valid_d)
  );

  always_comb begin
    we_d    = grant_d ? m1_we    : m0_we;
    addr_d  = grant_d ? m1_addr  : m0_addr;
    wdata_d = grant_d ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    misaligned_d = (addr_d[1:0] != 2'b00);
`else
    misaligned_d = 1'b0;
`endif
  end

  // Strobes are registered on entry to ACCESS so they are high exactly in ACCESS
  // and clear asynchronously with rst, cancelling an in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_d) begin
            sel_q        <= grant_d;
            last_grant_q <= grant_d;
            we_q         <= we_d;
            if (misaligned_d) begin
              state_q  <= ACK;
              m0_ack_q <= ~grant_d;
              m1_ack_q <= grant_d;
              m0_err_q <= ~grant_d;
              m1_err_q <= grant_d;
            end else begin
              state_q     <= ACCESS;
              mem_addr_q  <= addr_d;
              mem_wdata_q <= wdata_d;
              mem_read_q  <= ~we_d;
              mem_write_q <= we_d;
            end
          end
        end
        ACCESS: begin
          state_q  <= ACK;
          m0_ack_q <= ~sel_q;
          m1_ack_q <= sel_q;
          if (!we_q) begin
            if (sel_q) m1_rdata_q <= mem_rdata;
            else       m0_rdata_q <= mem_rdata;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule
